karatsuba_mult_arbiter: RTL and testbench
=========================================

Name: karatsuba_mult_arbiter

Overview:
Round-robin scheduler that shares one fully pipelined karatsuba_mult_axis_1v0 instance between N_REQ requesters. It accepts operand pairs through valid/ready handshakes and issues at most one pair per cycle to the multiplier. A tag pipeline matched to the multiplier latency carries the requester ID, so each product is returned to the requester that issued it. It also tracks in-flight operations and flags result/tag misalignment.

Parameters:
WIDTH, 328, operand width; products are 2*WIDTH.
N_REQ, 4, number of requesters (2..8).
LATENCY, 4, cycles from m_tvalid sampled high at multiplier input to matching m_z_tvalid high.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
hold  in  1  when high, no new grants; in-flight operations drain normally.
req_valid  in  N_REQ  per-requester operand-pair valid.
req_ready  out  N_REQ  one-hot (or zero) grant; transfer when req_valid[i]&req_ready[i].
req_x  in  N_REQ*WIDTH  flattened X operands; requester i at [i*WIDTH +: WIDTH].
req_y  in  N_REQ*WIDTH  flattened Y operands, same packing.
m_tvalid  out  1  drives multiplier X_tvalid and Y_tvalid.
m_x_tdata  out  WIDTH  drives multiplier X_tdata.
m_y_tdata  out  WIDTH  drives multiplier Y_tdata.
m_z_tvalid  in  1  multiplier Z_tvalid.
m_z_tdata  in  2*WIDTH  multiplier Z_tdata.
res_valid  out  N_REQ  one-cycle pulse to the owning requester.
res_data  out  2*WIDTH  product, shared bus, meaningful only when |res_valid.
in_flight  out  $clog2(LATENCY+3)  accepted but not yet returned operations.
idle  out  1  in_flight==0.
sync_err  out  1  sticky misalignment flag.

Behaviour:
- Reset (async assert): m_tvalid=0, m_x/y_tdata=0, res_valid=0, res_data=0, in_flight=0, sync_err=0, rr pointer=0, tag pipeline all invalid. idle reads 1 during and after reset.
- Grant is combinational:
  - If hold=0, req_ready selects the first i with req_valid[i]=1, searching from pointer upward with wrap modulo N_REQ.
  - If hold=1 or no req_valid, req_ready=0.
  - No requester waits more than N_REQ-1 grants.
- Pointer update:
  - On a transfer by requester g, pointer <= (g+1) mod N_REQ.
  - With no transfer, the pointer holds.
- Issue:
  - The cycle after a transfer, m_tvalid=1 and m_x/y_tdata carry that requester's operands.
  - With no transfer, m_tvalid=0 and the data registers hold their last values.
  - Peak rate is one issue per cycle.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, id}, loaded with {m_tvalid, id} of the issuing requester.
  - The tail aligns with m_z_tvalid/m_z_tdata of the same operation.
- Return:
  - When the tail tag is valid, the next cycle res_valid[id]=1 and res_data=m_z_tdata. All other res_valid bits are 0.
  - Total latency from accepting edge to res_valid = LATENCY+2 cycles.
- Misalignment:
  - If the tail tag valid != m_z_tvalid, sync_err <= 1 and stays set until rst.
  - Routing follows the tag, not m_z_tvalid.
- in_flight:
  - +1 on each transfer; -1 on each res_valid pulse; unchanged when both occur in the same cycle.
  - Never overflows: maximum LATENCY+2 with back-to-back issue.
- hold rising mid-stream: operations already accepted complete and return; in_flight reaches 0 within LATENCY+2 cycles.
- hold rising in the same cycle as req_valid: no grant that cycle.
- Reset mid-operation: all tags are discarded and no res_valid is emitted for operations accepted before reset, even if the multiplier later outputs products.
- Requester i holding req_valid without ready: its operands may change. Only the value present at the transfer cycle is issued.

Test Plan:
- Single request: N_REQ=4, LATENCY=4. Req1 presents x=3, y=5 for one cycle, accepted at cycle t → res_valid=4'b0010 at t+6, res_data=15, in_flight 1→0, idle=1 after.
- Round robin: all four req_valid held high, pointer=0 → grants 0,1,2,3,0 on consecutive cycles. Results return in the same order, one per cycle, each with its own product (x=i+2, y=7 → 14, 21, 28, 35); in_flight saturates at 6.
- Skip and wrap: pointer=2 and only req0 and req3 valid → grant 3 then 0, pointer ends at 1.
- Hold: hold=1 while req2 is valid → req_ready=0 for the full hold. In-flight ops still return. After hold=0, req2 is granted the next cycle.
- Misalignment: inject m_z_tvalid=1 one cycle early with no matching tag → sync_err=1 persists; no spurious res_valid.
- Async reset mid-stream: assert rst between clock edges with 3 ops in flight → outputs clear immediately, in_flight=0. No res_valid for those ops; the first request after deassertion is granted to req0.

Source files
------------

// File: rtl/karatsuba_mult_arbiter_if.sv
// karatsuba_mult_arbiter_if: bundles the requester, multiplier and status signals of the arbiter.
// Ports: slave modport = arbiter side (drives grants, multiplier operands, results, status);
//        master modport = environment side (requesters plus the shared multiplier).
interface karatsuba_mult_arbiter_if #(
  parameter int WIDTH   = 328,
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4
);
  localparam int CNT_W = $clog2(LATENCY + 3);

  // requester side
  logic                     hold;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH-1:0]   req_x;
  logic [N_REQ*WIDTH-1:0]   req_y;
  // shared multiplier
  logic                     m_tvalid;
  logic [WIDTH-1:0]         m_x_tdata;
  logic [WIDTH-1:0]         m_y_tdata;
  logic                     m_z_tvalid;
  logic [2*WIDTH-1:0]       m_z_tdata;
  // result return and status
  logic [N_REQ-1:0]         res_valid;
  logic [2*WIDTH-1:0]       res_data;
  logic [CNT_W-1:0]         in_flight;
  logic                     idle;
  logic                     sync_err;

  modport slave (
    input  hold, req_valid, req_x, req_y, m_z_tvalid, m_z_tdata,
    output req_ready, m_tvalid, m_x_tdata, m_y_tdata,
    output res_valid, res_data, in_flight, idle, sync_err
  );

  modport master (
    output hold, req_valid, req_x, req_y, m_z_tvalid, m_z_tdata,
    input  req_ready, m_tvalid, m_x_tdata, m_y_tdata,
    input  res_valid, res_data, in_flight, idle, sync_err
  );
endinterface

// File: rtl/karatsuba_mult_arbiter.sv
// karatsuba_mult_arbiter: round-robin sharing of one pipelined Karatsuba multiplier among N_REQ requesters.
// Latency: LATENCY+2 cycles from accepting edge to res_valid pulse; peak one issue per cycle.
// Backpressure: one-hot req_ready grant, withheld while hold=1; results are pushed and cannot stall.
// Ports: clk, rst (async, active-high) plus bus (slave modport): req_valid/ready/x/y, m_tvalid/x/y,
//        m_z_tvalid/tdata, res_valid/data, in_flight, idle, sync_err.
module karatsuba_mult_arbiter #(
  parameter int WIDTH   = 328,
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4
) (
  input logic                       clk,
  input logic                       rst,
  karatsuba_mult_arbiter_if.slave   bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 3);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    grant_id;
  logic               xfer;
  logic [N_REQ-1:0]   grant;
  logic               m_tvalid_q;
  logic [WIDTH-1:0]   m_x_q;
  logic [WIDTH-1:0]   m_y_q;
  logic [ID_W-1:0]    issue_id_q;
  logic [LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];
  logic [N_REQ-1:0]   res_valid_q;
  logic [2*WIDTH-1:0] res_data_q;
  logic [CNT_W-1:0]   in_flight_q;
  logic               sync_err_q;

  // (a + k) mod N_REQ without relying on N_REQ being a power of two
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester at or after the pointer wins; hold masks every grant.
  always_comb begin
    xfer     = 1'b0;
    grant_id = '0;
    grant    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!xfer && bus.req_valid[wrap_add(ptr_q, k)]) begin
        xfer     = 1'b1;
        grant_id = wrap_add(ptr_q, k);
      end
    end
    if (bus.hold) xfer = 1'b0;
    if (xfer) grant = N_REQ'(1) << grant_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      m_tvalid_q  <= 1'b0;
      m_x_q       <= '0;
      m_y_q       <= '0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      in_flight_q <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      // issue stage: operands captured only on the transfer cycle, held otherwise
      m_tvalid_q <= xfer;
      if (xfer) begin
        ptr_q      <= wrap_add(grant_id, 1);
        m_x_q      <= bus.req_x[grant_id*WIDTH +: WIDTH];
        m_y_q      <= bus.req_y[grant_id*WIDTH +: WIDTH];
        issue_id_q <= grant_id;
      end

      // tag pipeline runs beside the multiplier; its tail lines up with m_z_*
      tag_v_q[0]  <= m_tvalid_q;
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end

      // routing trusts the tag; a disagreeing m_z_tvalid only raises the sticky flag
      res_valid_q <= tag_v_q[LATENCY-1] ? (N_REQ'(1) << tag_id_q[LATENCY-1]) : '0;
      if (tag_v_q[LATENCY-1]) res_data_q <= bus.m_z_tdata;
      if (tag_v_q[LATENCY-1] != bus.m_z_tvalid) sync_err_q <= 1'b1;

      case ({xfer, |res_valid_q})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.m_tvalid  = m_tvalid_q;
  assign bus.m_x_tdata = m_x_q;
  assign bus.m_y_tdata = m_y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.in_flight = in_flight_q;
  assign bus.idle      = (in_flight_q == '0);
  assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_karatsuba_mult_arbiter.sv
// tb_karatsuba_mult_arbiter: directed bench for the round-robin multiplier arbiter.
// Includes a behavioural LATENCY-stage multiplier with an injectable spurious m_z_tvalid.
// Ports: none (top-level bench).
module tb_karatsuba_mult_arbiter;
  localparam int WIDTH   = 328;
  localparam int N_REQ   = 4;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inj = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  karatsuba_mult_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LATENCY(LATENCY)) bus ();

  karatsuba_mult_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // multiplier model: not reset, so products of discarded operations still emerge
  logic               mv [LATENCY];
  logic [2*WIDTH-1:0] mz [LATENCY];
  always @(posedge clk) begin
    mv[0] <= bus.m_tvalid;
    mz[0] <= {{WIDTH{1'b0}}, bus.m_x_tdata} * {{WIDTH{1'b0}}, bus.m_y_tdata};
    for (int s = 1; s < LATENCY; s++) begin
      mv[s] <= mv[s-1];
      mz[s] <= mz[s-1];
    end
  end
  assign bus.m_z_tvalid = mv[LATENCY-1] | inj;
  assign bus.m_z_tdata  = mz[LATENCY-1];

  // round-robin expectations, one entry per cycle
  logic [3:0] exp_rr [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] exp_rv [15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  int         exp_rd [15] = '{0, 0, 0, 0, 0, 0, 14, 21, 28, 35, 14, 21, 28, 35, 0};
  int         exp_if [15] = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};

  task automatic chk(input string tag, input logic [2*WIDTH-1:0] obs, input logic [2*WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    bus.req_x[i*WIDTH +: WIDTH] = x;
    bus.req_y[i*WIDTH +: WIDTH] = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;

    // reset asserted asynchronously before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_x", bus.m_x_tdata, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_in_flight", bus.in_flight, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_sync_err", bus.sync_err, 0);
    chk("rst_ready", bus.req_ready, 0);
    repeat (LATENCY + 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_idle", bus.idle, 1);

    // round robin: all four valid for 8 cycles, x=i+2, y=7
    for (int i = 0; i < N_REQ; i++) put(i, WIDTH'(i + 2), WIDTH'(7));
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("rr_ready_%0d", k), bus.req_ready, exp_rr[k]);
      chk($sformatf("rr_res_valid_%0d", k), bus.res_valid, exp_rv[k]);
      if (exp_rv[k] != 4'h0) chk($sformatf("rr_res_data_%0d", k), bus.res_data, exp_rd[k]);
      chk($sformatf("rr_in_flight_%0d", k), bus.in_flight, exp_if[k]);
    end
    chk("rr_idle", bus.idle, 1);
    chk("rr_sync_err", bus.sync_err, 0);

    // single request from req1 (pointer 0): 3*5 returns six cycles later
    @(negedge clk);
    put(1, 3, 5);
    bus.req_valid = 4'b0010;
    #1;
    chk("single_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("single_m_tvalid", bus.m_tvalid, 1);
    chk("single_m_x", bus.m_x_tdata, 3);
    chk("single_m_y", bus.m_y_tdata, 5);
    chk("single_in_flight", bus.in_flight, 1);
    @(negedge clk); #1;
    chk("single_m_tvalid_low", bus.m_tvalid, 0);
    chk("single_m_x_hold", bus.m_x_tdata, 3);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("single_no_res_%0d", k), bus.res_valid, 0);
    end
    @(negedge clk); #1;
    chk("single_res_valid", bus.res_valid, 4'b0010);
    chk("single_res_data", bus.res_data, 15);
    chk("single_in_flight_at_res", bus.in_flight, 1);
    @(negedge clk); #1;
    chk("single_res_clear", bus.res_valid, 0);
    chk("single_in_flight_end", bus.in_flight, 0);
    chk("single_idle", bus.idle, 1);

    // skip and wrap (pointer 2): req3 then req0; req0 changes operands while waiting
    @(negedge clk);
    put(0, 11, 13);
    put(3, 17, 19);
    bus.req_valid = 4'b1001;
    #1;
    chk("wrap_grant3", bus.req_ready, 4'b1000);
    @(negedge clk);
    put(0, 12, 13);
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap_grant0", bus.req_ready, 4'b0001);
    chk("wrap_issue3_x", bus.m_x_tdata, 17);
    @(negedge clk);
    bus.req_valid = 4'b0011;
    #1;
    chk("wrap_ptr_probe", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    #1;
    chk("wrap_issue0_x", bus.m_x_tdata, 12);
    chk("wrap_no_valid", bus.req_ready, 0);
    repeat (4) @(negedge clk); #1;
    chk("wrap_res3_valid", bus.res_valid, 4'b1000);
    chk("wrap_res3_data", bus.res_data, 323);
    @(negedge clk); #1;
    chk("wrap_res0_valid", bus.res_valid, 4'b0001);
    chk("wrap_res0_data", bus.res_data, 156);

    // hold (pointer 1): req1 in flight, hold and req2 rise together
    @(negedge clk);
    put(1, 6, 8);
    bus.req_valid = 4'b0010;
    #1;
    chk("hold_pre_grant", bus.req_ready, 4'b0010);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.hold = 1'b1;
        put(2, 9, 9);
        bus.req_valid = 4'b0100;
      end
      #1;
      chk($sformatf("hold_ready_%0d", k), bus.req_ready, 0);
      chk($sformatf("hold_res_valid_%0d", k), bus.res_valid, (k == 6) ? 4'b0010 : 4'b0000);
      if (k == 6) chk("hold_res_data", bus.res_data, 48);
    end
    chk("hold_drained", bus.in_flight, 0);
    chk("hold_idle", bus.idle, 1);
    @(negedge clk);
    bus.hold = 1'b0;
    #1;
    chk("hold_release_grant", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("hold_issue_x", bus.m_x_tdata, 9);
    repeat (5) @(negedge clk); #1;
    chk("hold_res2_valid", bus.res_valid, 4'b0100);
    chk("hold_res2_data", bus.res_data, 81);

    // misalignment (pointer 3): spurious m_z_tvalid one cycle ahead of a real product
    @(negedge clk);
    put(0, 4, 5);
    bus.req_valid = 4'b0001;
    #1;
    chk("mis_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk); #1;
    chk("mis_err_before", bus.sync_err, 0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    chk("mis_err_set", bus.sync_err, 1);
    chk("mis_no_spurious", bus.res_valid, 0);
    @(negedge clk); #1;
    chk("mis_res_valid", bus.res_valid, 4'b0001);
    chk("mis_res_data", bus.res_data, 20);
    chk("mis_err_sticky", bus.sync_err, 1);

    // async reset mid-stream (pointer 1): three ops accepted, then rst between edges
    @(negedge clk);
    put(0, 2, 7);
    put(1, 3, 7);
    put(2, 4, 7);
    bus.req_valid = 4'b0111;
    #1;
    chk("rst_g1", bus.req_ready, 4'b0010);
    @(negedge clk); #1;
    chk("rst_g2", bus.req_ready, 4'b0100);
    @(negedge clk); #1;
    chk("rst_g0", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("rst_in_flight_3", bus.in_flight, 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_m_tvalid", bus.m_tvalid, 0);
    chk("arst_in_flight", bus.in_flight, 0);
    chk("arst_idle", bus.idle, 1);
    chk("arst_sync_err", bus.sync_err, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_no_res_4", bus.res_valid, 0);
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("arst_no_res_%0d", k), bus.res_valid, 0);
    end
    chk("arst_orphan_err", bus.sync_err, 1);
    chk("arst_in_flight_zero", bus.in_flight, 0);
    @(negedge clk);
    bus.req_valid = 4'b0011;
    #1;
    chk("arst_first_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("arst_new_in_flight", bus.in_flight, 1);
    repeat (5) @(negedge clk); #1;
    chk("arst_new_res_valid", bus.res_valid, 4'b0001);
    chk("arst_new_res_data", bus.res_data, 14);
    @(negedge clk); #1;
    chk("arst_new_idle", bus.idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
